// File: rtl/itype_tracker.sv
// itype_tracker: classifies up to NRET committed instructions per cycle into
// trace itype codes, latches interrupt pulses until they fit into a free port,
// squashes ports younger than an excepting one, and presents the result
// through a one-deep output register.
//
// Handshake: an input beat is accepted on a clock edge where
// ready_o = ~valid_o | ready_i. While ready_o is low, upstream must hold the
// beat. interrupt_i is the exception: it is sampled on every edge. The output
// beat (valid_o, chan_valid_o, itype_o, iaddr_o) stays unchanged while
// valid_o & ~ready_i.

package connector_pkg;
  parameter int ITYPE_LEN = 4;
  parameter int XLEN      = 64;

  typedef enum logic [3:0] {
    ADD, EQ, NE, LTS, GES, LTU, GEU, JALR, MRET, SRET, DRET
  } fu_op;

  typedef enum logic [2:0] {
    NoCF, Branch, Jump, JumpR, Return
  } cf_t;
endpackage

module itype_tracker #(
  parameter int  NRET      = 2,
  parameter int  ITYPE_LEN = connector_pkg::ITYPE_LEN,
  parameter int  XLEN      = connector_pkg::XLEN,
  localparam int IdxW      = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NRET-1:0]                       valid_i,
  input  connector_pkg::fu_op [NRET-1:0]        op_i,
  input  connector_pkg::cf_t  [NRET-1:0]        cf_type_i,
  input  logic [NRET-1:0]                       branch_taken_i,
  input  logic [NRET-1:0]                       link_i,
  input  logic [NRET-1:0][XLEN-1:0]             pc_i,
  input  logic [NRET-1:0][XLEN-1:0]             disc_pc_i,
  input  logic                                  exception_i,
  input  logic [IdxW-1:0]                       exc_idx_i,
  input  logic                                  interrupt_i,
  output logic                                  ready_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [NRET-1:0]                       chan_valid_o,
  output logic [NRET-1:0][ITYPE_LEN-1:0]        itype_o,
  output logic [NRET-1:0][XLEN-1:0]             iaddr_o
);
  import connector_pkg::*;

  localparam logic [ITYPE_LEN-1:0] IT_NONE   = ITYPE_LEN'(0);
  localparam logic [ITYPE_LEN-1:0] IT_EXC    = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] IT_IRQ    = ITYPE_LEN'(2);
  localparam logic [ITYPE_LEN-1:0] IT_ERET   = ITYPE_LEN'(3);
  localparam logic [ITYPE_LEN-1:0] IT_NTAKEN = ITYPE_LEN'(4);
  localparam logic [ITYPE_LEN-1:0] IT_TAKEN  = ITYPE_LEN'(5);
  localparam logic [ITYPE_LEN-1:0] IT_UNINF3 = ITYPE_LEN'(6);
  localparam logic [ITYPE_LEN-1:0] IT_UCALL  = ITYPE_LEN'(8);
  localparam logic [ITYPE_LEN-1:0] IT_ICALL  = ITYPE_LEN'(9);
  localparam logic [ITYPE_LEN-1:0] IT_UJUMP  = ITYPE_LEN'(10);
  localparam logic [ITYPE_LEN-1:0] IT_IJUMP  = ITYPE_LEN'(11);

  logic                           valid_q;
  logic [NRET-1:0]                chan_valid_q, chan_valid_d;
  logic [NRET-1:0][ITYPE_LEN-1:0] itype_q, itype_d;
  logic [NRET-1:0][XLEN-1:0]      iaddr_q, iaddr_d;
  logic                           irq_pend_q, irq_pend_d;
  logic                           irq_ins;
  logic                           accept;

  // Itype of one valid, non-excepting port; the call/jump split only exists
  // in the 4-bit encoding.
  function automatic logic [ITYPE_LEN-1:0] classify(
    input fu_op op,
    input cf_t  cf,
    input logic taken,
    input logic link,
    input logic same
  );
    logic [ITYPE_LEN-1:0] code;
    code = IT_NONE;
    if ((op inside {MRET, SRET, DRET}) && (cf == Return) && same) begin
      code = IT_ERET;
    end else if ((op inside {EQ, NE, LTS, GES, LTU, GEU}) && (cf == Branch) && same) begin
      code = taken ? IT_TAKEN : IT_NTAKEN;
    end else if ((op == JALR) || (cf == JumpR)) begin
      code = (ITYPE_LEN == 3) ? IT_UNINF3 : (link ? IT_UCALL : IT_UJUMP);
    end else if ((cf == Jump) && taken && same) begin
      code = (ITYPE_LEN == 3) ? IT_NONE : (link ? IT_ICALL : IT_IJUMP);
    end
    return code;
  endfunction

  assign accept  = ~valid_q | ready_i;
  assign ready_o = accept;

  // Build the next output beat: classify, squash younger ports, then drop a
  // pending interrupt into the lowest free port.
  always_comb begin
    chan_valid_d = '0;
    itype_d      = '0;
    iaddr_d      = '0;
    irq_ins      = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      iaddr_d[k] = pc_i[k];
      if (exception_i && (int'(exc_idx_i) == k)) begin
        chan_valid_d[k] = 1'b1;
        itype_d[k]      = IT_EXC;
      end else if (!(exception_i && (k > int'(exc_idx_i))) && valid_i[k]) begin
        chan_valid_d[k] = 1'b1;
        itype_d[k]      = classify(op_i[k], cf_type_i[k], branch_taken_i[k],
                                   link_i[k], pc_i[k] == disc_pc_i[k]);
      end
    end
    if (irq_pend_q && !exception_i) begin
      for (int k = 0; k < NRET; k++) begin
        if (!irq_ins && !chan_valid_d[k]) begin
          irq_ins         = 1'b1;
          chan_valid_d[k] = 1'b1;
          itype_d[k]      = IT_IRQ;
          iaddr_d[k]      = '0;
        end
      end
    end
  end

  // Pending interrupt: cleared when inserted into an accepted beat, and a new
  // pulse in the same cycle wins over the clear.
  always_comb begin
    irq_pend_d = (irq_pend_q & ~(accept & irq_ins)) | interrupt_i;
  end

  // Output register, loaded on every accepted beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      chan_valid_q <= '0;
      itype_q      <= '0;
      iaddr_q      <= '0;
    end else if (accept) begin
      valid_q      <= |chan_valid_d;
      chan_valid_q <= chan_valid_d;
      itype_q      <= itype_d;
      iaddr_q      <= iaddr_d;
    end
  end

  // Interrupt latch register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_pend_q <= 1'b0;
    end else begin
      irq_pend_q <= irq_pend_d;
    end
  end

  assign valid_o      = valid_q;
  assign chan_valid_o = chan_valid_q;
  assign itype_o      = itype_q;
  assign iaddr_o      = iaddr_q;
endmodule

// File: doc/itype_tracker.md
# itype_tracker

Multi-port, registered successor of the single-port instruction-type classifier in the CVA6 trace-encoder connector. It classifies up to NRET committed instructions per cycle into trace itype codes and adds call detection for the 4-bit itype mode. Interrupt pulses are latched until they can be emitted, and exceptions squash younger ports. Results go through a one-deep output register with a valid/ready handshake toward the encoder front end.

## Interface

Parameters:
- NRET, 2: number of commit ports (1..4).
- ITYPE_LEN, connector_pkg::ITYPE_LEN: itype width, 3 or 4.
- XLEN, connector_pkg::XLEN: address width.

Ports:
- clk_i, in, 1: single clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- valid_i, in, NRET: per-port committed-instruction valid.
- op_i, in, NRET x connector_pkg::fu_op: functional-unit op per port.
- cf_type_i, in, NRET x connector_pkg::cf_t: control-flow type per port.
- branch_taken_i, in, NRET: branch/jump resolved taken.
- link_i, in, NRET: destination register is x1/x5 (call indicator).
- pc_i, in, NRET x XLEN: committed PC.
- disc_pc_i, in, NRET x XLEN: PC of the resolving control-flow instruction.
- exception_i, in, 1: exception on the port given by exc_idx_i.
- exc_idx_i, in, clog2(NRET) (min 1): excepting port index.
- interrupt_i, in, 1: interrupt pulse, taken in any cycle.
- ready_o, out, 1: input beat accepted this cycle.
- valid_o, out, 1: output beat valid.
- ready_i, in, 1: downstream accepts the output beat.
- chan_valid_o, out, NRET: per-port output valid.
- itype_o, out, NRET x ITYPE_LEN: per-port itype.
- iaddr_o, out, NRET x XLEN: per-port address.

## Operation

- Input beat accepted when ready_o = ~valid_o | ready_i. If ready_o is low, upstream holds the beat; only interrupt_i is sampled regardless.
- Per-port classification of an accepted beat, in priority order:
  - 1 (exception): port == exc_idx_i and exception_i, even if valid_i is low.
  - 3 (eret): MRET/SRET/DRET, cf Return, pc_i == disc_pc_i.
  - 4 (not-taken branch) or 5 (taken branch): EQ/NE/LTS/GES/LTU/GEU, cf Branch, pc_i == disc_pc_i, selected by branch_taken_i.
  - Uninferable: JALR or cf JumpR.
    - ITYPE_LEN=3: 6.
    - ITYPE_LEN=4: 8 if link_i, else 10.
  - Inferable: cf Jump, branch_taken_i, pc_i == disc_pc_i.
    - ITYPE_LEN=4: 9 if link_i, else 11.
    - ITYPE_LEN=3: 0.
  - 0 otherwise.
  - Codes 1 and 3–11 require valid_i on that port, except code 1 as stated above.
- Exception squash: ports with index > exc_idx_i get chan_valid_o=0 and itype 0, whatever their valid_i.
- chan_valid_o[k] = valid_i[k] or (k is the excepting port), after squash. iaddr_o[k] = pc_i[k].
- Interrupt latch irq_pend:
  - Set by interrupt_i in any cycle.
  - A second pulse while pending merges into the same pending interrupt; no count is kept.
  - Inserted into the lowest-index port whose chan_valid_o would be 0 in the next accepted beat: itype 2, chan_valid_o=1, iaddr_o=0.
  - Not inserted in a beat carrying an exception; it stays pending.
  - If every port is occupied, it stays pending.
  - An accepted beat with no input valids and irq_pend set produces an interrupt-only beat.
  - irq_pend is cleared on insertion. An interrupt_i in that same cycle re-sets it.
- valid_o = OR of the next chan_valid_o, registered on acceptance. Beats with no valid port do not raise valid_o.

## Timing

- Latency: 1 cycle from the accepted input edge to valid_o/itype_o.
- Reset (async, rst_ni=0): valid_o=0, chan_valid_o=0, itype_o=0, iaddr_o=0, irq_pend=0, ready_o=1.
  - Reset mid-stall drops the held beat and any pending interrupt.
- Output stays stable while valid_o & ~ready_i.
- Throughput: 1 beat/cycle when ready_i=1.
- interrupt_i is edge-free: a level held for N cycles still yields one pending interrupt until it is inserted.

## Test plan

1. NRET=2, ITYPE_LEN=3:
   - Stimulus: port0 BEQ taken (pc=disc_pc=0x100), port1 JALR, ready_i=1.
   - Response: next cycle valid_o=1, itype={6,5}, chan_valid_o=2'b11, iaddr={pc1,0x100}.
2. ITYPE_LEN=4, one port each case:
   - JAL with link_i=1 → 9; JAL with link_i=0 → 11.
   - JALR with link_i=1 → 8; JALR with link_i=0 → 10.
   - ITYPE_LEN=3, JAL → 0.
3. exception_i=1, exc_idx_i=0, both ports valid → port0 itype 1, port1 chan_valid_o=0/itype 0.
4. interrupt_i pulse while both ports valid:
   - Stimulus: next beat port0 only valid.
   - Response: first beat carries no interrupt. Second beat has port1 itype 2, iaddr 0. irq_pend then cleared.
5. ready_i=0 for 3 cycles with valid_o=1:
   - Outputs hold and ready_o=0.
   - interrupt_i pulsed during the stall appears in the first beat after ready_i returns.
6. rst_ni low while valid_o=1 and irq_pend=1 → all outputs 0 asynchronously. After release, no stale interrupt beat.
